snn_frame_ctrl: RTL

Parametrised frame controller between the UART receiver/transmitter and the SNN core. It unpacks received bytes LSB-first into single-bit writes to the input RAM. After a full frame it starts the core, hands the RAM read address to the core, and transmits the ASCII result. It then re-arms automatically for the next frame.

---
 rtl/snn_pkg.sv | 22 ++
 rtl/snn_frame_ctrl_bit_unpacker.sv | 37 +++
 rtl/snn_frame_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared types, constants and parameter check for the SNN frame controller
package snn_pkg;

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_WRITE = 3'd1,
        ST_START = 3'd2,
        ST_CALC  = 3'd3,
        ST_TX    = 3'd4
    } frame_state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;

    // True when the frame fits in the input RAM and the digit fits one ASCII decimal offset
    function automatic bit params_ok(input int num_inputs, input int addr_w, input int digit_w);
        longint ram_depth;
        ram_depth = longint'(1) << addr_w;
        return (num_inputs >= 1) && (longint'(num_inputs) <= ram_depth) &&
               (digit_w >= 1) && (digit_w <= 4);
    endfunction

endpackage

// File: rtl/snn_frame_ctrl_bit_unpacker.sv
// rtl/snn_frame_ctrl_bit_unpacker.sv - byte shift register that emits bits LSB-first
module bit_unpacker #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_shift,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_bit,
    output logic              o_last_bit
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] r_shreg;
    logic [CNT_W-1:0]  r_bit_cnt;

    // Load a fresh byte and restart the count, or shift one bit out per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
        end else if (i_load) begin
            r_shreg   <= i_data;
            r_bit_cnt <= '0;
        end else if (i_shift) begin
            r_shreg   <= r_shreg >> 1;
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
    end

    assign o_bit      = r_shreg[0];
    assign o_last_bit = (r_bit_cnt == LAST_CNT);

endmodule

// File: rtl/snn_frame_ctrl.sv
// rtl/snn_frame_ctrl.sv - UART-to-SNN frame controller: unpack, start core, report ASCII result
module snn_frame_ctrl
    import snn_pkg::*;
#(
    parameter int NUM_INPUTS = 784,
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 10,
    parameter int DIGIT_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_rx_rdy,
    input  logic [DATA_W-1:0]  i_rx_data,
    output logic [ADDR_W-1:0]  o_ram_addr,
    output logic               o_ram_wdata,
    output logic               o_ram_we,
    input  logic [ADDR_W-1:0]  i_core_addr,
    output logic               o_core_start,
    input  logic               i_core_done,
    input  logic [DIGIT_W-1:0] i_core_digit,
    output logic               o_tx_start,
    output logic [7:0]         o_tx_data,
    input  logic               i_tx_rdy,
    output logic [7:0]         o_led,
    output logic               o_busy,
    output logic               o_overrun
);

    if (!params_ok(NUM_INPUTS, ADDR_W, DIGIT_W)) begin : g_param_err
        $error("snn_frame_ctrl: NUM_INPUTS must be 1..2**ADDR_W and DIGIT_W 1..4");
    end

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_INPUTS - 1);

    frame_state_t      r_state;
    frame_state_t      w_next;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_led;
    logic [7:0]        r_tx_data;
    logic              r_busy;
    logic              r_overrun;

    logic              w_load;
    logic              w_shift;
    logic              w_bit;
    logic              w_last_bit;
    logic              w_frame_end;
    logic              w_result_take;
    logic [7:0]        w_digit_ext;
    logic [7:0]        w_ascii;

    bit_unpacker #(
        .DATA_W (DATA_W)
    ) u_unpacker (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_shift    (w_shift),
        .i_data     (i_rx_data),
        .o_bit      (w_bit),
        .o_last_bit (w_last_bit)
    );

    assign w_frame_end   = (r_wr_addr == LAST_ADDR);
    assign w_result_take = (r_state == ST_CALC) && i_core_done;
    assign w_digit_ext   = {{(8 - DIGIT_W){1'b0}}, i_core_digit};
    assign w_ascii       = ASCII_ZERO + w_digit_ext;

    // Next-state and Mealy outputs; the RAM port is muxed between writer and core
    always_comb begin
        w_next       = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        o_ram_addr   = r_wr_addr;
        o_ram_wdata  = 1'b0;
        o_ram_we     = 1'b0;
        o_core_start = 1'b0;
        o_tx_start   = 1'b0;
        case (r_state)
            ST_LOAD: begin
                if (i_rx_rdy) begin
                    w_load = 1'b1;
                    w_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                o_ram_we    = 1'b1;
                o_ram_wdata = w_bit;
                w_shift     = 1'b1;
                // Frame end wins: leftover bits of a partial last byte are dropped
                if (w_frame_end) begin
                    w_next = ST_START;
                end else if (w_last_bit) begin
                    w_next = ST_LOAD;
                end
            end
            ST_START: begin
                o_core_start = 1'b1;
                w_next       = ST_CALC;
            end
            ST_CALC: begin
                o_ram_addr = i_core_addr;
                if (i_core_done) begin
                    w_next = ST_TX;
                end
            end
            ST_TX: begin
                if (i_tx_rdy) begin
                    o_tx_start = 1'b1;
                    w_next     = ST_LOAD;
                end
            end
            default: begin
                w_next = ST_LOAD;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    // Write address advances per written bit and rewinds when the core is started
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_addr <= '0;
        end else if (r_state == ST_START) begin
            r_wr_addr <= '0;
        end else if (r_state == ST_WRITE) begin
            r_wr_addr <= r_wr_addr + ADDR_W'(1);
        end
    end

    // Capture the ASCII result on the edge that enters TX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led     <= '0;
            r_tx_data <= '0;
        end else if (w_result_take) begin
            r_led     <= w_ascii;
            r_tx_data <= w_ascii;
        end
    end

    // Busy tracks the state being entered; overrun latches any byte arriving outside LOAD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_busy <= (w_next != ST_LOAD);
            if (i_rx_rdy && (r_state != ST_LOAD)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_tx_data = r_tx_data;
    assign o_led     = r_led;
    assign o_busy    = r_busy;
    assign o_overrun = r_overrun;

endmodule
